ltc2308_scan_ctrl: RTL and testbench

LTC2308_SCAN_CTRL -- requirements
Module: ltc2308_scan_ctrl

---
 rtl/ltc2308_pkg.sv | 31 +++
 rtl/ltc2308_sck_gen.sv | 47 ++++
 rtl/ltc2308_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ltc2308_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltc2308_pkg.sv
// ltc2308_pkg
// Shared definitions for the LTC2308 scan controller: the controller state
// encoding, the fixed bits of the 6-bit LTC2308 configuration word, the
// function that builds that word for a channel, and default timing values.
package ltc2308_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_SHIFT,
    ST_GAP
  } state_t;

  // Fixed configuration bits: single-ended, unipolar, no sleep.
  localparam logic CFG_SD  = 1'b1;
  localparam logic CFG_UNI = 1'b1;
  localparam logic CFG_SLP = 1'b0;

  localparam int DEF_CONV_CYCLES = 80;
  localparam int DEF_SCK_DIV     = 2;
  localparam int DEF_GAP_CYCLES  = 16;

  localparam int FRAME_BITS = 12;

  // Word sent MSB first: S/D, O/S, S1, S0, UNI, SLP. The LTC2308 channel
  // mux maps O/S to the channel LSB, S1 to the MSB and S0 to the middle bit.
  function automatic logic [5:0] cfg_word(input logic [2:0] ch);
    return {CFG_SD, ch[0], ch[2], ch[1], CFG_UNI, CFG_SLP};
  endfunction

endpackage

// File: rtl/ltc2308_sck_gen.sv
// ltc2308_sck_gen
// Serial clock generator. While en is high it produces SCK periods that start
// low and then go high, each half lasting SCK_DIV clk cycles. The strobes are
// combinational and flag the clk edge at which SCK will change.
//   clk, reset_n : clock and asynchronous active-low reset
//   en           : run SCK (low and counters cleared while 0)
//   sck          : registered serial clock, idle low
//   sck_rise     : the coming edge drives sck 0->1
//   sck_fall     : the coming edge drives sck 1->0 (end of a period)
module ltc2308_sck_gen
  import ltc2308_pkg::*;
#(
  parameter int SCK_DIV = DEF_SCK_DIV
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int CW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

  logic [CW-1:0] div_cnt_reg;
  logic          half_end;

  assign half_end = en && (div_cnt_reg == CW'(SCK_DIV - 1));
  assign sck_rise = half_end && !sck;
  assign sck_fall = half_end && sck;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_reg <= '0;
      sck         <= 1'b0;
    end else if (!en) begin
      div_cnt_reg <= '0;
      sck         <= 1'b0;
    end else if (half_end) begin
      div_cnt_reg <= '0;
      sck         <= ~sck;
    end else begin
      div_cnt_reg <= div_cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/ltc2308_scan_ctrl.sv
// ltc2308_scan_ctrl
// Scans LTC2308 channels 0..last_ch. Each frame is CONV (CONVST high), SHIFT
// (12 SCK periods: config word out on SDI, result in from SDO) and GAP.
// The ADC returns the conversion configured one frame earlier, so the first
// frame of a scan is a prime frame whose read-back is discarded.
//   start, continuous, last_ch : scan control (last_ch latched at start)
//   adc_convst/sck/sdi, adc_sdo : LTC2308 pins
//   result_valid/ch/data        : one pulse per converted channel
//   busy, scan_done             : not idle / pulse with channel last_ch
module ltc2308_scan_ctrl
  import ltc2308_pkg::*;
#(
  parameter int CONV_CYCLES = DEF_CONV_CYCLES,
  parameter int SCK_DIV     = DEF_SCK_DIV,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        continuous,
  input  logic [2:0]  last_ch,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  output logic        result_valid,
  output logic [2:0]  result_ch,
  output logic [11:0] result_data,
  output logic        busy,
  output logic        scan_done
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  state_t      state_reg;
  logic [15:0] cyc_cnt_reg;
  logic [3:0]  bit_cnt_reg;    // SCK periods completed in this frame
  logic [11:0] shift_reg;
  logic [4:0]  cfg_sh_reg;     // config bits still to be sent
  logic [2:0]  cfg_ch_reg;     // channel configured in this frame
  logic [2:0]  rd_ch_reg;      // channel whose result is read in this frame
  logic [2:0]  last_ch_reg;
  logic        prime_reg;
  logic        res_pend_reg;
  logic        done_pend_reg;

  logic        sck_en;
  logic        sck_rise;
  logic        sck_fall;
  logic [5:0]  cfg_cur;
  logic [2:0]  cfg_ch_next;

  assign sck_en      = (state_reg == ST_SHIFT);
  assign cfg_cur     = cfg_word(cfg_ch_reg);
  assign cfg_ch_next = (cfg_ch_reg == last_ch_reg) ? 3'd0 : cfg_ch_reg + 3'd1;

  ltc2308_sck_gen #(
    .SCK_DIV (SCK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (sck_en),
    .sck      (adc_sck),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      cyc_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      cfg_sh_reg    <= '0;
      cfg_ch_reg    <= '0;
      rd_ch_reg     <= '0;
      last_ch_reg   <= '0;
      prime_reg     <= 1'b0;
      res_pend_reg  <= 1'b0;
      done_pend_reg <= 1'b0;
      adc_convst    <= 1'b0;
      adc_sdi       <= 1'b0;
      result_valid  <= 1'b0;
      result_ch     <= '0;
      result_data   <= '0;
      busy          <= 1'b0;
      scan_done     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      scan_done    <= 1'b0;

      // Results are published one cycle after the 12th SDO sample.
      if (res_pend_reg) begin
        result_valid <= 1'b1;
        result_ch    <= rd_ch_reg;
        result_data  <= shift_reg;
        scan_done    <= done_pend_reg;
        res_pend_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg   <= ST_CONV;
            adc_convst  <= 1'b1;
            busy        <= 1'b1;
            cyc_cnt_reg <= '0;
            last_ch_reg <= last_ch;
            cfg_ch_reg  <= 3'd0;
            prime_reg   <= 1'b1;
          end
        end

        ST_CONV: begin
          if (cyc_cnt_reg == 16'(CONV_CYCLES - 1)) begin
            state_reg   <= ST_SHIFT;
            adc_convst  <= 1'b0;
            bit_cnt_reg <= '0;
            adc_sdi     <= cfg_cur[5];
            cfg_sh_reg  <= cfg_cur[4:0];
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
          end
        end

        ST_SHIFT: begin
          if (sck_rise) begin
            shift_reg <= {shift_reg[10:0], adc_sdo};
            if (bit_cnt_reg == LAST_BIT) begin
              res_pend_reg  <= !prime_reg;
              done_pend_reg <= (rd_ch_reg == last_ch_reg);
            end
          end
          if (sck_fall) begin
            if (bit_cnt_reg == LAST_BIT) begin
              state_reg   <= ST_GAP;
              adc_sdi     <= 1'b0;
              cyc_cnt_reg <= '0;
              bit_cnt_reg <= '0;
            end else begin
              // Zeros shift in behind the config bits, so SDI is 0 after
              // the sixth period.
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              adc_sdi     <= cfg_sh_reg[4];
              cfg_sh_reg  <= {cfg_sh_reg[3:0], 1'b0};
            end
          end
        end

        ST_GAP: begin
          if (cyc_cnt_reg == 16'(GAP_CYCLES - 1)) begin
            if (!prime_reg && (rd_ch_reg == last_ch_reg) && !continuous) begin
              state_reg <= ST_IDLE;
              busy      <= 1'b0;
            end else begin
              state_reg   <= ST_CONV;
              adc_convst  <= 1'b1;
              cyc_cnt_reg <= '0;
              rd_ch_reg   <= cfg_ch_reg;
              cfg_ch_reg  <= cfg_ch_next;
              prime_reg   <= 1'b0;
            end
          end else begin
            cyc_cnt_reg <= cyc_cnt_reg + 16'd1;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ltc2308_scan_ctrl.sv
// tb_ltc2308_scan_ctrl
// Two controllers (default timing, and SCK_DIV=1 / CONV_CYCLES=4) each driven
// by a behavioural LTC2308: it latches the config word from SDI on SCK rises,
// converts that channel at the next CONVST and shifts the code out on SDO,
// MSB first, advancing on SCK falls.
module tb_ltc2308_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rstn, start_s, cont_s;
  logic [1:0]  convst, sck, sdi, sdo, rv, sd, busy;
  logic [2:0]  last0, last1, rc0, rc1;
  logic [11:0] rd0, rd1;

  ltc2308_scan_ctrl dut0 (
    .clk(clk), .reset_n(rstn[0]), .start(start_s[0]), .continuous(cont_s[0]),
    .last_ch(last0), .adc_convst(convst[0]), .adc_sck(sck[0]), .adc_sdi(sdi[0]),
    .adc_sdo(sdo[0]), .result_valid(rv[0]), .result_ch(rc0), .result_data(rd0),
    .busy(busy[0]), .scan_done(sd[0])
  );

  ltc2308_scan_ctrl #(.CONV_CYCLES(4), .SCK_DIV(1), .GAP_CYCLES(16)) dut1 (
    .clk(clk), .reset_n(rstn[1]), .start(start_s[1]), .continuous(cont_s[1]),
    .last_ch(last1), .adc_convst(convst[1]), .adc_sck(sck[1]), .adc_sdi(sdi[1]),
    .adc_sdo(sdo[1]), .result_valid(rv[1]), .result_ch(rc1), .result_data(rd1),
    .busy(busy[1]), .scan_done(sd[1])
  );

  localparam logic [11:0] CODES [8] = '{12'h123, 12'h456, 12'h789, 12'hA5C,
                                        12'hFFF, 12'h000, 12'h801, 12'h3C3};
  localparam logic [5:0] SDI_WORDS [8] = '{6'b100010, 6'b110010, 6'b100110, 6'b110110,
                                           6'b101010, 6'b111010, 6'b101110, 6'b111110};

  // ---------------- ADC model and output monitor ----------------
  logic [11:0] sh [2]        = '{12'h0, 12'h0};
  logic [11:0] conv_code [2] = '{12'h0, 12'h0};
  logic [5:0]  cap_w [2]     = '{6'h0, 6'h0};
  int          cap_n [2]     = '{0, 0};
  logic        p_cv [2]      = '{1'b0, 1'b0};
  logic        p_sck [2]     = '{1'b0, 1'b0};
  int rise_n [2] = '{0, 0};
  int frm_n  [2] = '{0, 0};
  int hi_run [2] = '{0, 0};
  int max_hi [2] = '{0, 0};
  int pv_n   [2] = '{0, 0};
  int sw_n   [2] = '{0, 0};
  logic [2:0]  pv_ch   [2][256];
  logic [11:0] pv_dat  [2][256];
  logic        pv_done [2][256];
  int          pv_t    [2][256];
  logic [5:0]  sw      [2][256];
  int tick = 0;

  assign sdo = {sh[1][11], sh[0][11]};

  always @(negedge clk) begin
    tick++;
    for (int k = 0; k < 2; k++) begin
      if (convst[k] && !p_cv[k]) begin
        frm_n[k]++;
        conv_code[k] = (cap_n[k] >= 6) ? CODES[{cap_w[k][3], cap_w[k][2], cap_w[k][4]}] : 12'h000;
      end
      if (!convst[k] && p_cv[k]) begin
        sh[k]    = conv_code[k];
        cap_n[k] = 0;
      end
      if (sck[k] && !p_sck[k]) begin
        rise_n[k]++;
        if (cap_n[k] < 6) begin
          cap_w[k] = {cap_w[k][4:0], sdi[k]};
          cap_n[k]++;
          if (cap_n[k] == 6) begin
            sw[k][sw_n[k] % 256] = cap_w[k];
            sw_n[k]++;
          end
        end
      end
      if (!sck[k] && p_sck[k]) sh[k] = {sh[k][10:0], 1'b0};
      if (sck[k]) begin
        hi_run[k] = p_sck[k] ? hi_run[k] + 1 : 1;
        if (hi_run[k] > max_hi[k]) max_hi[k] = hi_run[k];
      end
      p_cv[k]  = convst[k];
      p_sck[k] = sck[k];
      if (rv[k]) begin
        pv_ch[k][pv_n[k] % 256]   = (k == 0) ? rc0 : rc1;
        pv_dat[k][pv_n[k] % 256]  = (k == 0) ? rd0 : rd1;
        pv_done[k][pv_n[k] % 256] = sd[k];
        pv_t[k][pv_n[k] % 256]    = tick;
        pv_n[k]++;
      end
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", nm, got, got, exp, exp);
    end else begin
      $display("ok   %s: %0d", nm, got);
    end
  endtask

  task automatic do_start(input int u, input logic [2:0] lc, input logic c);
    @(posedge clk); #1;
    if (u == 0) last0 = lc; else last1 = lc;
    cont_s[u]  = c;
    start_s[u] = 1'b1;
    @(posedge clk); #1;
    start_s[u] = 1'b0;
  endtask

  task automatic wait_idle(input int u, input int budget, output int blen);
    int n = 0;
    blen = 0;
    while (busy[u] && n < budget) begin
      @(negedge clk);
      if (busy[u]) blen++;
      n++;
    end
    if (busy[u]) begin
      total++; bad++;
      $display("FAIL wait_idle u=%0d: still busy after %0d cycles, expected idle", u, budget);
    end
  endtask

  typedef struct {
    int         u;
    logic [2:0] lc;
    int         n_pulse;
    int         n_frame;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int pb, fb, sb, rb, blen, u, n;

    vecs[0] = '{u: 0, lc: 3'd2, n_pulse: 3, n_frame: 4};
    vecs[1] = '{u: 0, lc: 3'd3, n_pulse: 4, n_frame: 5};
    vecs[2] = '{u: 0, lc: 3'd0, n_pulse: 1, n_frame: 2};
    vecs[3] = '{u: 1, lc: 3'd7, n_pulse: 8, n_frame: 9};
    vecs[4] = '{u: 1, lc: 3'd2, n_pulse: 3, n_frame: 4};

    rstn = 2'b00; start_s = 2'b00; cont_s = 2'b00; last0 = 3'd0; last1 = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_convst", int'(convst), 0);
    check("rst_sck", int'(sck), 0);
    check("rst_sdi", int'(sdi), 0);
    check("rst_valid", int'(rv), 0);
    check("rst_done", int'(sd), 0);
    check("rst_ch0", rc0, 0);
    check("rst_data0", rd0, 0);
    check("rst_data1", rd1, 0);
    @(posedge clk); #1 rstn = 2'b11;
    repeat (2) @(posedge clk);

    // ---- table-driven single scans ----
    for (int v = 0; v < 5; v++) begin
      u  = vecs[v].u;
      pb = pv_n[u]; fb = frm_n[u]; sb = sw_n[u]; rb = rise_n[u];
      do_start(u, vecs[v].lc, 1'b0);
      wait_idle(u, 3000, blen);
      $display("vector %0d: u=%0d last_ch=%0d busy_len=%0d pulses=%0d", v, u, vecs[v].lc, blen, pv_n[u] - pb);
      check($sformatf("v%0d_busy_len", v), blen, vecs[v].n_frame * ((u == 0) ? 144 : 44));
      check($sformatf("v%0d_pulses", v), pv_n[u] - pb, vecs[v].n_pulse);
      check($sformatf("v%0d_frames", v), frm_n[u] - fb, vecs[v].n_frame);
      for (int i = 0; i < vecs[v].n_pulse; i++) begin
        check($sformatf("v%0d_p%0d_ch", v, i), pv_ch[u][(pb + i) % 256], i);
        check($sformatf("v%0d_p%0d_data", v, i), pv_dat[u][(pb + i) % 256], CODES[i]);
        check($sformatf("v%0d_p%0d_done", v, i), pv_done[u][(pb + i) % 256], (i == vecs[v].n_pulse - 1) ? 1 : 0);
      end
      check($sformatf("v%0d_sdi_words", v), sw_n[u] - sb, vecs[v].n_frame);
      for (int f = 0; f < vecs[v].n_frame; f++)
        check($sformatf("v%0d_f%0d_sdi", v, f), sw[u][(sb + f) % 256], SDI_WORDS[f % vecs[v].n_pulse]);
      if (u == 1) begin
        check($sformatf("v%0d_sck_rises", v), rise_n[1] - rb, 12 * vecs[v].n_frame);
        check($sformatf("v%0d_sck_high_run", v), max_hi[1], 1);
      end
    end

    // ---- continuous scan, deasserted mid second pass ----
    pb = pv_n[0];
    do_start(0, 3'd7, 1'b1);
    n = 0;
    while (pv_n[0] - pb < 10 && n < 20 * 144) begin
      @(negedge clk);
      n++;
    end
    check("cont_reached10", (pv_n[0] - pb >= 10) ? 1 : 0, 1);
    cont_s[0] = 1'b0;
    wait_idle(0, 20 * 144, blen);
    $display("continuous: pulses=%0d", pv_n[0] - pb);
    check("cont_pulses", pv_n[0] - pb, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("cont_p%0d_ch", i), pv_ch[0][(pb + i) % 256], i % 8);
      check($sformatf("cont_p%0d_data", i), pv_dat[0][(pb + i) % 256], CODES[i % 8]);
      if (i > 0)
        check($sformatf("cont_p%0d_spacing", i), pv_t[0][(pb + i) % 256] - pv_t[0][(pb + i - 1) % 256], 144);
    end
    check("cont_done7", pv_done[0][(pb + 7) % 256], 1);
    check("cont_done15", pv_done[0][(pb + 15) % 256], 1);

    // ---- extra starts and last_ch changes while busy ----
    pb = pv_n[0];
    do_start(0, 3'd2, 1'b0);
    repeat (200) @(posedge clk);
    do_start(0, 3'd5, 1'b0);
    repeat (150) @(posedge clk);
    do_start(0, 3'd6, 1'b0);
    wait_idle(0, 3000, blen);
    $display("extra starts: pulses=%0d", pv_n[0] - pb);
    check("xs_pulses", pv_n[0] - pb, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("xs_p%0d_ch", i), pv_ch[0][(pb + i) % 256], i);
      check($sformatf("xs_p%0d_data", i), pv_dat[0][(pb + i) % 256], CODES[i]);
    end

    // ---- reset in the middle of SHIFT of the first non-prime frame ----
    pb = pv_n[0];
    do_start(0, 3'd1, 1'b0);
    repeat (144 + 80 + 10) @(posedge clk);
    #1 rstn[0] = 1'b0;
    #1;
    $display("reset mid-shift applied");
    check("mrst_convst", convst[0], 0);
    check("mrst_sck", sck[0], 0);
    check("mrst_sdi", sdi[0], 0);
    check("mrst_valid", rv[0], 0);
    check("mrst_done", sd[0], 0);
    check("mrst_busy", busy[0], 0);
    check("mrst_ch", rc0, 0);
    check("mrst_data", rd0, 0);
    repeat (300) @(posedge clk);
    check("mrst_no_pulse", pv_n[0] - pb, 0);
    #1 rstn[0] = 1'b1;
    repeat (2) @(posedge clk);
    pb = pv_n[0];
    do_start(0, 3'd1, 1'b0);
    wait_idle(0, 3000, blen);
    $display("after reset: pulses=%0d", pv_n[0] - pb);
    check("post_busy_len", blen, 3 * 144);
    check("post_pulses", pv_n[0] - pb, 2);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("post_p%0d_ch", i), pv_ch[0][(pb + i) % 256], i);
      check($sformatf("post_p%0d_data", i), pv_dat[0][(pb + i) % 256], CODES[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
